// File: rtl/prog_launch_sequencer_if.sv
// Handshake bundle between the launch sequencer and the top level / PC / core.
interface prog_launch_sequencer_if #(
    parameter int L  = 10,
    parameter int CW = 16
);
    logic          Start;
    logic          Halt;
    logic          PcLoad;
    logic [L-1:0]  PcTarget;
    logic          CoreEn;
    logic          Busy;
    logic [1:0]    ProgIdx;
    logic          Done;
    logic          TimedOut;
    logic [CW-1:0] CycleCnt;
    logic          AllDone;

    modport master (
        input  Start, Halt,
        output PcLoad, PcTarget, CoreEn, Busy, ProgIdx, Done, TimedOut, CycleCnt, AllDone
    );

    modport slave (
        output Start, Halt,
        input  PcLoad, PcTarget, CoreEn, Busy, ProgIdx, Done, TimedOut, CycleCnt, AllDone
    );
endinterface

// File: rtl/prog_launch_sequencer.sv
// Steps the core through a fixed table of programs: load entry PC, run until Halt or
// watchdog expiry, report per-program RUN cycle count, then park once the table is spent.
module prog_launch_sequencer #(
    parameter int              L       = 10,
    parameter int              NPROG   = 3,
    parameter logic [NPROG*L-1:0] ENTRY = {10'd4, 10'd2, 10'd1},
    parameter int              CW      = 16,
    parameter int              TIMEOUT = 4096
) (
    input  logic                   Clk,
    input  logic                   Reset,
    prog_launch_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FINISH, SPENT} state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]    LAST_IX = 2'(NPROG - 1);

    state_t        state, state_nxt;
    logic [1:0]    prog_idx;
    logic [CW-1:0] cycle_cnt;
    logic          timed_out;
    logic          to_hit;
    logic          last_prog;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign to_hit    = TO_EN && (cycle_cnt == TO_LAST);
    assign last_prog = (prog_idx == LAST_IX);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (bus.Halt || to_hit) state_nxt = FINISH;
            FINISH:  state_nxt = last_prog ? SPENT : IDLE;
            SPENT:   state_nxt = SPENT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.PcLoad  = (state == LOAD);
        bus.CoreEn  = (state == RUN);
        bus.Busy    = (state == LOAD) || (state == RUN) || (state == FINISH);
        bus.Done    = (state == FINISH);
        bus.AllDone = (state == SPENT);
    end

    // Per-program bookkeeping; Halt has priority over the watchdog in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prog_idx  <= '0;
            cycle_cnt <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Start) begin
                    cycle_cnt <= '0;
                    timed_out <= 1'b0;
                end
                RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (!bus.Halt && to_hit) timed_out <= 1'b1;
                end
                FINISH: if (!last_prog) prog_idx <= prog_idx + 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.ProgIdx  = prog_idx;
    assign bus.CycleCnt = cycle_cnt;
    assign bus.TimedOut = timed_out;
    assign bus.PcTarget = ENTRY[int'(prog_idx)*L +: L];

endmodule

// File: tb/tb_prog_launch_sequencer.sv
// Directed checks of the launch sequencer: main instance with an 8-cycle watchdog,
// plus a narrow-counter instance with the watchdog disabled for saturation.
module tb_prog_launch_sequencer;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    prog_launch_sequencer_if #(.L(10), .CW(16)) bus_a ();
    prog_launch_sequencer_if #(.L(10), .CW(4))  bus_b ();

    prog_launch_sequencer #(
        .L(10), .NPROG(3), .ENTRY({10'd4, 10'd2, 10'd1}), .CW(16), .TIMEOUT(8)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a)
    );

    prog_launch_sequencer #(
        .L(10), .NPROG(1), .ENTRY(10'd7), .CW(4), .TIMEOUT(0)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Start pulse; ends in the first RUN cycle.
    task automatic launch(input string tag, input logic [9:0] target);
        bus_a.Start = 1'b1;
        tick();
        bus_a.Start = 1'b0;
        chk({tag, ".pcload"}, bus_a.PcLoad, 1);
        chk({tag, ".target"}, bus_a.PcTarget, target);
        chk({tag, ".coreen_load"}, bus_a.CoreEn, 0);
        tick();
        chk({tag, ".coreen_run"}, bus_a.CoreEn, 1);
    endtask

    // From first RUN cycle, raise Halt on RUN cycle n; ends in FINISH.
    task automatic run_halt(input int n);
        for (int i = 1; i < n; i++) tick();
        bus_a.Halt = 1'b1;
        tick();
        bus_a.Halt = 1'b0;
    endtask

    initial begin
        bus_a.Start = 1'b0; bus_a.Halt = 1'b0;
        bus_b.Start = 1'b0; bus_b.Halt = 1'b0;
        do_reset();

        chk("rst.pcload",  bus_a.PcLoad, 0);
        chk("rst.coreen",  bus_a.CoreEn, 0);
        chk("rst.busy",    bus_a.Busy, 0);
        chk("rst.done",    bus_a.Done, 0);
        chk("rst.idx",     bus_a.ProgIdx, 0);
        chk("rst.cnt",     bus_a.CycleCnt, 0);
        chk("rst.to",      bus_a.TimedOut, 0);
        chk("rst.alldone", bus_a.AllDone, 0);

        // Launch latency and a 5-cycle program
        bus_a.Start = 1'b1;
        tick();
        bus_a.Start = 1'b0;
        chk("t1.pcload", bus_a.PcLoad, 1);
        chk("t1.target", bus_a.PcTarget, 1);
        chk("t1.busy",   bus_a.Busy, 1);
        chk("t1.coreen0", bus_a.CoreEn, 0);
        tick();
        chk("t1.coreen1", bus_a.CoreEn, 1);
        chk("t1.pcload0", bus_a.PcLoad, 0);
        chk("t1.cnt0",    bus_a.CycleCnt, 0);
        run_halt(5);
        chk("t2.done",   bus_a.Done, 1);
        chk("t2.coreen", bus_a.CoreEn, 0);
        chk("t2.cnt",    bus_a.CycleCnt, 5);
        tick();
        chk("t2.done0",  bus_a.Done, 0);
        chk("t2.idx",    bus_a.ProgIdx, 1);
        chk("t2.busy",   bus_a.Busy, 0);
        chk("t2.to",     bus_a.TimedOut, 0);
        chk("t2.cnthold", bus_a.CycleCnt, 5);

        // Remaining programs, then the sequence is spent
        launch("t3a", 10'd2);
        run_halt(3);
        chk("t3a.cnt", bus_a.CycleCnt, 3);
        tick();
        chk("t3a.idx", bus_a.ProgIdx, 2);
        launch("t3b", 10'd4);
        run_halt(2);
        chk("t3b.done",    bus_a.Done, 1);
        chk("t3b.alldone0", bus_a.AllDone, 0);
        tick();
        chk("t3b.alldone", bus_a.AllDone, 1);
        chk("t3b.busy",    bus_a.Busy, 0);
        chk("t3b.idx",     bus_a.ProgIdx, 2);
        chk("t3b.done0",   bus_a.Done, 0);
        bus_a.Start = 1'b1;
        tick();
        chk("t3c.pcload", bus_a.PcLoad, 0);
        tick();
        bus_a.Start = 1'b0;
        chk("t3c.pcload2", bus_a.PcLoad, 0);
        chk("t3c.alldone", bus_a.AllDone, 1);

        // Watchdog: expires on RUN cycle 8
        do_reset();
        chk("t4.alldone_rst", bus_a.AllDone, 0);
        launch("t4a", 10'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("t4a.still_run", bus_a.CoreEn, 1);
        chk("t4a.cnt7",      bus_a.CycleCnt, 7);
        tick();
        chk("t4a.done", bus_a.Done, 1);
        chk("t4a.cnt",  bus_a.CycleCnt, 8);
        chk("t4a.to",   bus_a.TimedOut, 1);
        tick();
        chk("t4a.tohold", bus_a.TimedOut, 1);
        chk("t4a.idx",    bus_a.ProgIdx, 1);
        bus_a.Start = 1'b1;
        tick();
        bus_a.Start = 1'b0;
        chk("t4b.toclr",  bus_a.TimedOut, 0);
        chk("t4b.cntclr", bus_a.CycleCnt, 0);
        tick();
        run_halt(8);
        chk("t4b.done", bus_a.Done, 1);
        chk("t4b.cnt",  bus_a.CycleCnt, 8);
        chk("t4b.to",   bus_a.TimedOut, 0);
        tick();
        chk("t4b.idx", bus_a.ProgIdx, 2);

        // Reset in the middle of program 1
        do_reset();
        launch("t5a", 10'd1);
        run_halt(1);
        tick();
        launch("t5b", 10'd2);
        tick();
        tick();
        chk("t5.cnt_pre", bus_a.CycleCnt, 2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t5.coreen",  bus_a.CoreEn, 0);
        chk("t5.idx",     bus_a.ProgIdx, 0);
        chk("t5.cnt",     bus_a.CycleCnt, 0);
        chk("t5.alldone", bus_a.AllDone, 0);
        chk("t5.busy",    bus_a.Busy, 0);

        // Start held through RUN, Halt outside RUN
        bus_a.Start = 1'b1;
        tick();
        chk("t6.pcload", bus_a.PcLoad, 1);
        bus_a.Halt = 1'b1;
        tick();
        bus_a.Halt = 1'b0;
        chk("t6.run",   bus_a.CoreEn, 1);
        chk("t6.nodone", bus_a.Done, 0);
        tick();
        tick();
        chk("t6.norelaunch", bus_a.PcLoad, 0);
        chk("t6.cnt2",       bus_a.CycleCnt, 2);
        bus_a.Halt = 1'b1;
        tick();
        bus_a.Halt = 1'b0;
        chk("t6.done", bus_a.Done, 1);
        chk("t6.cnt",  bus_a.CycleCnt, 3);
        tick();
        chk("t6.idle_done", bus_a.Done, 0);
        chk("t6.idle_load", bus_a.PcLoad, 0);
        bus_a.Halt = 1'b1;
        tick();
        bus_a.Halt = 1'b0;
        bus_a.Start = 1'b0;
        chk("t6.relaunch", bus_a.PcLoad, 1);
        chk("t6.target2",  bus_a.PcTarget, 2);
        chk("t6.nodone2",  bus_a.Done, 0);
        tick();
        chk("t6.cnt_after_halt_idle", bus_a.CycleCnt, 0);

        // Counter saturation with watchdog disabled
        bus_b.Start = 1'b1;
        tick();
        bus_b.Start = 1'b0;
        chk("sat.pcload", bus_b.PcLoad, 1);
        chk("sat.target", bus_b.PcTarget, 7);
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("sat.run", bus_b.CoreEn, 1);
        chk("sat.cnt", bus_b.CycleCnt, 15);
        chk("sat.to",  bus_b.TimedOut, 0);
        bus_b.Halt = 1'b1;
        tick();
        bus_b.Halt = 1'b0;
        chk("sat.done", bus_b.Done, 1);
        chk("sat.cnt2", bus_b.CycleCnt, 15);
        tick();
        chk("sat.alldone", bus_b.AllDone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
